// File: rtl/neighbor_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : neighbor_table_ctrl
// Purpose  : Packet sequencer for neighborTable: slot assignment, heartbeat
//            clear, and best-next-hop rescan after every table write.
// Revision : 1.0
// ============================================================================
module neighbor_table_ctrl #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 16,
    parameter int IDX_WIDTH     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [1:0]            pkt_type,
    input  logic [WORD_WIDTH-1:0] pkt_id,
    input  logic [WORD_WIDTH-1:0] pkt_hops,
    input  logic [WORD_WIDTH-1:0] pkt_qvalue,
    input  logic [WORD_WIDTH-1:0] pkt_energy,
    input  logic [WORD_WIDTH-1:0] pkt_chhops,
    output logic                  tbl_wr_en,
    output logic                  tbl_hb_reset,
    output logic [WORD_WIDTH-1:0] tbl_node_id,
    output logic [WORD_WIDTH-1:0] tbl_node_hops,
    output logic [WORD_WIDTH-1:0] tbl_node_qvalue,
    output logic [WORD_WIDTH-1:0] tbl_node_energy,
    output logic [WORD_WIDTH-1:0] tbl_node_chhops,
    output logic [IDX_WIDTH-1:0]  tbl_neighbor_count,
    output logic [IDX_WIDTH-1:0]  nbr_count,
    output logic                  table_full,
    output logic                  drop_pulse,
    output logic                  best_valid,
    output logic [WORD_WIDTH-1:0] best_id,
    output logic [WORD_WIDTH-1:0] best_qvalue,
    output logic [WORD_WIDTH-1:0] best_hops
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CLEAR  = 3'd1;
    localparam logic [2:0] c_ST_LOOKUP = 3'd2;
    localparam logic [2:0] c_ST_WRITE  = 3'd3;
    localparam logic [2:0] c_ST_SCAN   = 3'd4;

    localparam logic [IDX_WIDTH-1:0]  c_MAX_CNT = IDX_WIDTH'(MAX_NEIGHBORS);
    localparam logic [IDX_WIDTH-1:0]  c_IDX_ONE = IDX_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] c_ONES    = '1;

    logic [2:0]            r_state;
    logic [2:0]            w_next;

    logic [WORD_WIDTH-1:0] r_pkt_id, r_pkt_hops, r_pkt_q, r_pkt_energy, r_pkt_chhops;
    logic [IDX_WIDTH-1:0]  r_nbr_count;
    logic                  r_append;

    logic [MAX_NEIGHBORS-1:0] r_sh_valid;
    logic [WORD_WIDTH-1:0]    r_sh_id   [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0]    r_sh_q    [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0]    r_sh_hops [MAX_NEIGHBORS];

    logic [WORD_WIDTH-1:0] r_tbl_id, r_tbl_hops, r_tbl_q, r_tbl_energy, r_tbl_chhops;
    logic [IDX_WIDTH-1:0]  r_tbl_slot;

    logic [IDX_WIDTH-1:0]  r_scan_idx;
    logic                  r_cand_valid;
    logic [WORD_WIDTH-1:0] r_cand_id, r_cand_q, r_cand_hops;

    logic                  r_best_valid;
    logic [WORD_WIDTH-1:0] r_best_id, r_best_q, r_best_hops;

    logic                  w_hs;
    logic                  w_full;
    logic                  w_match;
    logic [IDX_WIDTH-1:0]  w_match_idx;
    logic                  w_drop;
    logic [WORD_WIDTH-1:0] w_sel_id, w_sel_q, w_sel_hops;
    logic                  w_take;
    logic [WORD_WIDTH-1:0] w_win_id, w_win_q, w_win_hops;
    logic                  w_scan_last;

    assign w_hs   = pkt_valid && (r_state == c_ST_IDLE);
    assign w_full = (r_nbr_count == c_MAX_CNT);
    assign w_drop = !w_match && w_full;

    // Lowest matching slot wins; IDs are unique in practice.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int k = MAX_NEIGHBORS - 1; k >= 0; k--) begin
            if (r_sh_valid[k] && (r_sh_id[k] == r_pkt_id)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_WIDTH'(k);
            end
        end
    end

    always_comb begin
        w_sel_id   = '0;
        w_sel_q    = '0;
        w_sel_hops = '0;
        for (int k = 0; k < MAX_NEIGHBORS; k++) begin
            if (r_scan_idx == IDX_WIDTH'(k)) begin
                w_sel_id   = r_sh_id[k];
                w_sel_q    = r_sh_q[k];
                w_sel_hops = r_sh_hops[k];
            end
        end
    end

    // Strict comparisons keep the earlier (lower) slot on a full tie.
    assign w_take      = !r_cand_valid || (w_sel_q > r_cand_q) ||
                         ((w_sel_q == r_cand_q) && (w_sel_hops < r_cand_hops));
    assign w_win_id    = w_take ? w_sel_id   : r_cand_id;
    assign w_win_q     = w_take ? w_sel_q    : r_cand_q;
    assign w_win_hops  = w_take ? w_sel_hops : r_cand_hops;
    assign w_scan_last = ((r_scan_idx + c_IDX_ONE) == r_nbr_count);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_hs) begin
                    if (pkt_type == 2'b01)      w_next = c_ST_LOOKUP;
                    else if (pkt_type == 2'b10) w_next = c_ST_CLEAR;
                end
            end
            c_ST_CLEAR:  w_next = c_ST_IDLE;
            c_ST_LOOKUP: w_next = w_drop ? c_ST_IDLE : c_ST_WRITE;
            c_ST_WRITE:  w_next = c_ST_SCAN;
            c_ST_SCAN:   if (w_scan_last) w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        pkt_ready    = 1'b0;
        tbl_wr_en    = 1'b0;
        tbl_hb_reset = 1'b0;
        drop_pulse   = 1'b0;
        case (r_state)
            c_ST_IDLE:   pkt_ready    = 1'b1;
            c_ST_CLEAR:  tbl_hb_reset = 1'b1;
            c_ST_LOOKUP: drop_pulse   = w_drop;
            c_ST_WRITE:  tbl_wr_en    = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_id     <= '0;
            r_pkt_hops   <= '0;
            r_pkt_q      <= '0;
            r_pkt_energy <= '0;
            r_pkt_chhops <= '0;
            r_nbr_count  <= '0;
            r_append     <= 1'b0;
            r_sh_valid   <= '0;
            for (int k = 0; k < MAX_NEIGHBORS; k++) begin
                r_sh_id[k]   <= '0;
                r_sh_q[k]    <= '0;
                r_sh_hops[k] <= '0;
            end
            r_tbl_id     <= '0;
            r_tbl_hops   <= c_ONES;
            r_tbl_q      <= '0;
            r_tbl_energy <= '0;
            r_tbl_chhops <= c_ONES;
            r_tbl_slot   <= '0;
            r_scan_idx   <= '0;
            r_cand_valid <= 1'b0;
            r_cand_id    <= '0;
            r_cand_q     <= '0;
            r_cand_hops  <= '0;
            r_best_valid <= 1'b0;
            r_best_id    <= '0;
            r_best_q     <= '0;
            r_best_hops  <= c_ONES;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hs) begin
                        r_pkt_id     <= pkt_id;
                        r_pkt_hops   <= pkt_hops;
                        r_pkt_q      <= pkt_qvalue;
                        r_pkt_energy <= pkt_energy;
                        r_pkt_chhops <= pkt_chhops;
                    end
                end
                c_ST_CLEAR: begin
                    r_nbr_count  <= '0;
                    r_sh_valid   <= '0;
                    r_best_valid <= 1'b0;
                    r_best_hops  <= c_ONES;
                end
                c_ST_LOOKUP: begin
                    if (!w_drop) begin
                        r_tbl_slot   <= w_match ? w_match_idx : r_nbr_count;
                        r_append     <= !w_match;
                        r_tbl_id     <= r_pkt_id;
                        r_tbl_hops   <= r_pkt_hops;
                        r_tbl_q      <= r_pkt_q;
                        r_tbl_energy <= r_pkt_energy;
                        r_tbl_chhops <= r_pkt_chhops;
                    end
                end
                c_ST_WRITE: begin
                    for (int k = 0; k < MAX_NEIGHBORS; k++) begin
                        if (r_tbl_slot == IDX_WIDTH'(k)) begin
                            r_sh_valid[k] <= 1'b1;
                            r_sh_id[k]    <= r_tbl_id;
                            r_sh_q[k]     <= r_tbl_q;
                            r_sh_hops[k]  <= r_tbl_hops;
                        end
                    end
                    if (r_append) r_nbr_count <= r_nbr_count + c_IDX_ONE;
                    r_scan_idx   <= '0;
                    r_cand_valid <= 1'b0;
                    r_best_valid <= 1'b0;
                end
                c_ST_SCAN: begin
                    r_cand_valid <= 1'b1;
                    r_cand_id    <= w_win_id;
                    r_cand_q     <= w_win_q;
                    r_cand_hops  <= w_win_hops;
                    r_scan_idx   <= r_scan_idx + c_IDX_ONE;
                    if (w_scan_last) begin
                        r_best_valid <= 1'b1;
                        r_best_id    <= w_win_id;
                        r_best_q     <= w_win_q;
                        r_best_hops  <= w_win_hops;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tbl_node_id        = r_tbl_id;
    assign tbl_node_hops      = r_tbl_hops;
    assign tbl_node_qvalue    = r_tbl_q;
    assign tbl_node_energy    = r_tbl_energy;
    assign tbl_node_chhops    = r_tbl_chhops;
    assign tbl_neighbor_count = r_tbl_slot;
    assign nbr_count          = r_nbr_count;
    assign table_full         = w_full;
    assign best_valid         = r_best_valid;
    assign best_id            = r_best_id;
    assign best_qvalue        = r_best_q;
    assign best_hops          = r_best_hops;

endmodule
`default_nettype wire

// File: tb/tb_neighbor_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_neighbor_table_ctrl
// Purpose  : Directed plus random-packet bench for neighbor_table_ctrl.
// Revision : 1.0
// ============================================================================
module tb_neighbor_table_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [1:0]  pkt_type;
    logic [15:0] pkt_id, pkt_hops, pkt_qvalue, pkt_energy, pkt_chhops;
    logic        tbl_wr_en, tbl_hb_reset;
    logic [15:0] tbl_node_id, tbl_node_hops, tbl_node_qvalue, tbl_node_energy, tbl_node_chhops;
    logic [4:0]  tbl_neighbor_count, nbr_count;
    logic        table_full, drop_pulse, best_valid;
    logic [15:0] best_id, best_qvalue, best_hops;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: slots fill contiguously, so slot k is valid iff k < m_cnt.
    int          m_cnt = 0;
    logic [15:0] m_id   [16];
    logic [15:0] m_q    [16];
    logic [15:0] m_hops [16];

    neighbor_table_ctrl #(.WORD_WIDTH(16), .MAX_NEIGHBORS(16), .IDX_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_type(pkt_type),
        .pkt_id(pkt_id), .pkt_hops(pkt_hops), .pkt_qvalue(pkt_qvalue),
        .pkt_energy(pkt_energy), .pkt_chhops(pkt_chhops),
        .tbl_wr_en(tbl_wr_en), .tbl_hb_reset(tbl_hb_reset),
        .tbl_node_id(tbl_node_id), .tbl_node_hops(tbl_node_hops),
        .tbl_node_qvalue(tbl_node_qvalue), .tbl_node_energy(tbl_node_energy),
        .tbl_node_chhops(tbl_node_chhops), .tbl_neighbor_count(tbl_neighbor_count),
        .nbr_count(nbr_count), .table_full(table_full), .drop_pulse(drop_pulse),
        .best_valid(best_valid), .best_id(best_id), .best_qvalue(best_qvalue),
        .best_hops(best_hops)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [15:0] id, input logic [15:0] hops,
                         input logic [15:0] q);
        pkt_valid  = 1'b1;
        pkt_type   = t;
        pkt_id     = id;
        pkt_hops   = hops;
        pkt_qvalue = q;
        pkt_energy = 16'($urandom);
        pkt_chhops = 16'($urandom);
    endtask

    task automatic send_nbr(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
        int          slot;
        bit          drop, append;
        int          bi;
        logic [15:0] en, ch;
        slot = -1;
        for (int k = 0; k < m_cnt; k++) if (m_id[k] == id) slot = k;
        drop   = (slot < 0) && (m_cnt == 16);
        append = (slot < 0) && !drop;
        if (append) slot = m_cnt;

        drive(2'b01, id, hops, q);
        en = pkt_energy;
        ch = pkt_chhops;
        chk("ready_before", pkt_ready, 1);
        tick();
        pkt_valid = 1'b0;
        chk("lookup_ready", pkt_ready, 0);
        chk("lookup_drop", drop_pulse, drop);
        chk("lookup_wr", tbl_wr_en, 0);
        if (drop) begin
            tick();
            chk("drop_ready", pkt_ready, 1);
            chk("drop_pulse_end", drop_pulse, 0);
            chk("drop_no_wr", tbl_wr_en, 0);
            chk("drop_full", table_full, 1);
            chk("drop_count", nbr_count, m_cnt);
            return;
        end
        m_id[slot]   = id;
        m_q[slot]    = q;
        m_hops[slot] = hops;
        if (append) m_cnt++;

        tick();
        chk("wr_en", tbl_wr_en, 1);
        chk("wr_slot", tbl_neighbor_count, slot);
        chk("wr_id", tbl_node_id, id);
        chk("wr_q", tbl_node_qvalue, q);
        chk("wr_hops", tbl_node_hops, hops);
        chk("wr_energy", tbl_node_energy, en);
        chk("wr_chhops", tbl_node_chhops, ch);
        for (int c = 0; c < m_cnt; c++) begin
            tick();
            chk("scan_busy", pkt_ready, 0);
            chk("scan_bv", best_valid, 0);
            chk("scan_wr", tbl_wr_en, 0);
        end
        bi = 0;
        for (int k = 1; k < m_cnt; k++)
            if (m_q[k] > m_q[bi] || (m_q[k] == m_q[bi] && m_hops[k] < m_hops[bi])) bi = k;
        tick();
        chk("done_ready", pkt_ready, 1);
        chk("best_valid", best_valid, 1);
        chk("best_id", best_id, m_id[bi]);
        chk("best_q", best_qvalue, m_q[bi]);
        chk("best_hops", best_hops, m_hops[bi]);
        chk("count", nbr_count, m_cnt);
        chk("full", table_full, (m_cnt == 16));
        chk("hold_id", tbl_node_id, id);
    endtask

    task automatic send_hb();
        drive(2'b10, 16'h0, 16'h0, 16'h0);
        tick();
        pkt_valid = 1'b0;
        chk("hb_pulse", tbl_hb_reset, 1);
        chk("hb_busy", pkt_ready, 0);
        tick();
        m_cnt = 0;
        chk("hb_pulse_end", tbl_hb_reset, 0);
        chk("hb_ready", pkt_ready, 1);
        chk("hb_count", nbr_count, 0);
        chk("hb_full", table_full, 0);
        chk("hb_bv", best_valid, 0);
        chk("hb_bhops", best_hops, 16'hFFFF);
    endtask

    task automatic send_ignored(input logic [1:0] t);
        drive(t, 16'h1234, 16'h1, 16'h1);
        tick();
        pkt_valid = 1'b0;
        chk("ign_ready", pkt_ready, 1);
        chk("ign_wr", tbl_wr_en, 0);
        chk("ign_hb", tbl_hb_reset, 0);
        chk("ign_drop", drop_pulse, 0);
        chk("ign_count", nbr_count, m_cnt);
    endtask

    initial begin
        rst = 1'b1;
        pkt_valid = 1'b0; pkt_type = 2'b00;
        pkt_id = '0; pkt_hops = '0; pkt_qvalue = '0; pkt_energy = '0; pkt_chhops = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", pkt_ready, 1);
        chk("rst_wr", tbl_wr_en, 0);
        chk("rst_hb", tbl_hb_reset, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_count", nbr_count, 0);
        chk("rst_full", table_full, 0);
        chk("rst_bv", best_valid, 0);
        chk("rst_bid", best_id, 0);
        chk("rst_bq", best_qvalue, 0);
        chk("rst_bhops", best_hops, 16'hFFFF);
        chk("rst_tid", tbl_node_id, 0);
        chk("rst_thops", tbl_node_hops, 16'hFFFF);
        chk("rst_tch", tbl_node_chhops, 16'hFFFF);
        chk("rst_tslot", tbl_neighbor_count, 0);

        // Reset asserted while a rescan is in progress
        send_nbr(16'd5, 16'd3, 16'h0100);
        send_nbr(16'd6, 16'd2, 16'h0200);
        drive(2'b01, 16'd7, 16'd1, 16'h0300);
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        chk("mid_scan_busy", pkt_ready, 0);
        rst = 1'b1;
        tick();
        chk("rst_scan_hb0", tbl_hb_reset, 0);
        tick();
        chk("rst_scan_hb1", tbl_hb_reset, 0);
        rst = 1'b0;
        m_cnt = 0;
        chk("rst_scan_ready", pkt_ready, 1);
        chk("rst_scan_count", nbr_count, 0);
        chk("rst_scan_bv", best_valid, 0);
        chk("rst_scan_bhops", best_hops, 16'hFFFF);

        send_hb();

        send_nbr(16'd65, 16'd2, 16'h0C00);
        send_nbr(16'd71, 16'd4, 16'h0A00);
        chk("t3_best_id", best_id, 16'd65);
        send_nbr(16'd71, 16'd1, 16'h0C00);
        chk("t4_best_id", best_id, 16'd71);
        chk("t4_count", nbr_count, 2);

        for (int i = 0; i < 14; i++)
            send_nbr(16'(100 + i), 16'($urandom_range(1, 8)), 16'($urandom_range(0, 15) << 8));
        chk("t5_full", table_full, 1);
        send_nbr(16'd200, 16'd1, 16'hFFFF);
        send_nbr(16'd105, 16'd1, 16'hF000);
        chk("t5_update_best", best_id, 16'd105);

        send_hb();
        send_nbr(16'd300, 16'd2, 16'h0500);
        send_hb();
        send_hb();
        send_ignored(2'b00);
        send_ignored(2'b11);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) send_hb();
            else if ($urandom_range(0, 9) == 0) send_ignored(2'($urandom_range(0, 1) * 3));
            else send_nbr(16'($urandom_range(1, 22)), 16'($urandom_range(1, 4)),
                          16'($urandom_range(0, 3) << 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
